ex_muldiv_unit: RTL and testbench

- Multi-cycle RV32M execution unit in the EX stage, beside the ALU.
- Its result is muxed into AluOutE, which the EX/MEM-WB segment register (MWSegReg) captures.
- Holds the front of the pipeline through stall_o until the result is ready, so MWSegReg only ever captures a finished product, quotient or remainder.
- Multiply takes 2 cycles; divide takes XLEN+1 cycles (iterative restoring); special-case divides take 1 cycle.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/div_step.sv | 22 ++
 rtl/ex_muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide execution unit:
// funct3 values, FSM state type and fixed RV32M constants.
package muldiv_pkg;

    localparam logic [6:0]  M_FUNCT7  = 7'b0000001;
    localparam logic [31:0] INT_MIN   = 32'h80000000;

    localparam logic [2:0]  F3_MUL    = 3'b000;
    localparam logic [2:0]  F3_MULH   = 3'b001;
    localparam logic [2:0]  F3_MULHSU = 3'b010;
    localparam logic [2:0]  F3_MULHU  = 3'b011;
    localparam logic [2:0]  F3_DIV    = 3'b100;
    localparam logic [2:0]  F3_DIVU   = 3'b101;
    localparam logic [2:0]  F3_REM    = 3'b110;
    localparam logic [2:0]  F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes:
// shift {rem,quo} left, subtract the divisor when it fits, shift in the quotient bit.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_rem_sh;
    logic          w_ge;

    // The shifted remainder is one bit wider than XLEN, so compare at XLEN+1 bits.
    assign w_rem_sh = {i_rem, i_quo[XLEN-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, i_divisor});
    assign o_rem    = w_ge ? (w_rem_sh[XLEN-1:0] - i_divisor) : w_rem_sh[XLEN-1:0];
    assign o_quo    = {i_quo[XLEN-2:0], w_ge};

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M unit in EX: 2-cycle multiply, XLEN+1-cycle restoring divide,
// 1-cycle divide special cases; stalls the front end until the result is ready.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] Op1,
    input  logic [XLEN-1:0] Op2,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [CNT_W-1:0] L_CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] L_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  L_ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  L_ONES     = {XLEN{1'b1}};

    state_t            r_state;
    logic [2:0]        r_f3;
    logic [XLEN-1:0]   r_op1;
    logic [XLEN-1:0]   r_op2;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_div;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_qneg;
    logic              r_rneg;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    logic              w_sgn;
    logic              w_div0;
    logic              w_ovf;
    logic              w_ext_a;
    logic              w_ext_b;
    logic [2*XLEN-1:0] w_a;
    logic [2*XLEN-1:0] w_b;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_rem_nx;
    logic [XLEN-1:0]   w_quo_nx;

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Divide-group decode on the live inputs, used only at acceptance.
    assign w_sgn  = ~funct3[0];
    assign w_div0 = (Op2 == L_ZERO);
    assign w_ovf  = w_sgn && (Op1 == INT_MIN) && (Op2 == L_ONES);

    // Operands sign-extended to 2*XLEN so the truncated product is the exact signed product.
    assign w_ext_a = (r_f3 != F3_MULHU) & r_op1[XLEN-1];
    assign w_ext_b = ((r_f3 == F3_MUL) || (r_f3 == F3_MULH)) & r_op2[XLEN-1];
    assign w_a     = {{XLEN{w_ext_a}}, r_op1};
    assign w_b     = {{XLEN{w_ext_b}}, r_op2};
    assign w_prod  = w_a * w_b;

    div_step #(.XLEN(XLEN)) u_div_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_div),
        .o_rem     (w_rem_nx),
        .o_quo     (w_quo_nx)
    );

    assign stall_o  = start & ~r_done;
    assign done_o   = r_done;
    assign result_o = r_result;

    // Control FSM and datapath registers; clear aborts but leaves the held result alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_f3     <= 3'b000;
            r_op1    <= L_ZERO;
            r_op2    <= L_ZERO;
            r_rem    <= L_ZERO;
            r_quo    <= L_ZERO;
            r_div    <= L_ZERO;
            r_cnt    <= {CNT_W{1'b0}};
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= L_ZERO;
        end else if (clear) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_f3  <= funct3;
                        r_op1 <= Op1;
                        r_op2 <= Op2;
                        if (!funct3[2]) begin
                            r_state <= ST_MUL;
                        end else if (w_div0) begin
                            r_result <= funct3[1] ? Op1 : L_ONES;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end else if (w_ovf) begin
                            r_result <= funct3[1] ? L_ZERO : INT_MIN;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_quo   <= neg_if(Op1, w_sgn & Op1[XLEN-1]);
                            r_div   <= neg_if(Op2, w_sgn & Op2[XLEN-1]);
                            r_rem   <= L_ZERO;
                            r_cnt   <= {CNT_W{1'b0}};
                            r_qneg  <= w_sgn & (Op1[XLEN-1] ^ Op2[XLEN-1]);
                            r_rneg  <= w_sgn & Op1[XLEN-1];
                            r_state <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    r_result <= (r_f3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
                    r_done   <= 1'b1;
                    r_state  <= ST_DONE;
                end
                ST_DIV: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt + L_CNT_ONE;
                    if (r_cnt == L_CNT_LAST) begin
                        r_result <= r_f3[1] ? neg_if(w_rem_nx, r_rneg) : neg_if(w_quo_nx, r_qneg);
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed table, hand-written corner
// sequences, and random operations against an arithmetic reference model.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] Op1;
    logic [31:0] Op2;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .start    (start),
        .funct3   (funct3),
        .Op1      (Op1),
        .Op2      (Op2),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    // Reference: RV32M semantics computed with wide integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        logic        ovf;
        sa  = longint'(signed'(a));
        sb  = longint'(signed'(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        ia  = int'(a);
        ib  = int'(b);
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (f3)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFFFFFF;
                if (ovf) return 32'h80000000;
                return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 32'h0) return 32'hFFFFFFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'h0) return a;
                if (ovf) return 32'h0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 32'h0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 2;
        if (b == 32'h0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        funct3 = f3;
        Op1    = a;
        Op2    = b;
        start  = 1'b1;
    endtask

    // Called at a falling edge in cycle c0; returns the cycle index of done_o.
    task automatic wait_done(output int lat, output logic [31:0] res, output logic stall_ok);
        lat      = -1;
        res      = 32'h0;
        stall_ok = 1'b1;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (done_o === 1'b1) begin
                lat = k;
                res = result_o;
                if (stall_o !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (stall_o !== 1'b1) stall_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          lat;
        logic [31:0] res;
        logic        ok;
        issue(v.f3, v.a, v.b);
        wait_done(lat, res, ok);
        check({v.name, " latency"}, 32'(lat), 32'(v.lat));
        check({v.name, " result"}, res, v.res);
        check({v.name, " stall"}, {31'h0, ok}, 32'h1);
        start = 1'b0;
        @(negedge clk);
        #1;
        check({v.name, " done one cycle"}, {31'h0, done_o}, 32'h0);
        check({v.name, " idle stall"}, {31'h0, stall_o}, 32'h0);
        check({v.name, " result held"}, result_o, v.res);
        @(negedge clk);
    endtask

    initial begin
        int          lat;
        int          seen;
        logic [31:0] res;
        logic        ok;
        vec_t        v;

        vecs.push_back('{"MUL -2*3",     3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, 2});
        vecs.push_back('{"MULH -2*3",    3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 2});
        vecs.push_back('{"MULHSU -2*3",  3'd2, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 2});
        vecs.push_back('{"MULHU -2*3",   3'd3, 32'hFFFFFFFE, 32'd3,        32'h00000002, 2});
        vecs.push_back('{"MULH min*min", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 2});
        vecs.push_back('{"DIV -7/2",     3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
        vecs.push_back('{"REM -7/2",     3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
        vecs.push_back('{"DIVU 100/7",   3'd5, 32'd100,      32'd7,        32'd14,       33});
        vecs.push_back('{"REMU 100/7",   3'd7, 32'd100,      32'd7,        32'd2,        33});
        vecs.push_back('{"DIVU 5/0",     3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
        vecs.push_back('{"REM 5/0",      3'd6, 32'd5,        32'd0,        32'd5,        1});
        vecs.push_back('{"DIV ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{"REM ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
        vecs.push_back('{"DIVU min/-1",  3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33});
        vecs.push_back('{"DIV min/1",    3'd4, 32'h80000000, 32'd1,        32'h80000000, 33});

        rst    = 1'b1;
        clear  = 1'b0;
        start  = 1'b0;
        funct3 = 3'd0;
        Op1    = 32'h0;
        Op2    = 32'h0;
        repeat (2) @(negedge clk);
        check("reset done_o", {31'h0, done_o}, 32'h0);
        check("reset result_o", result_o, 32'h0);
        check("reset stall_o", {31'h0, stall_o}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back: MUL then DIVU with start held high throughout.
        issue(3'd0, 32'd6, 32'd7);
        wait_done(lat, res, ok);
        check("b2b mul latency", 32'(lat), 32'd2);
        check("b2b mul result", res, 32'd42);
        check("b2b mul stall", {31'h0, ok}, 32'h1);
        issue(3'd5, 32'd42, 32'd6);
        @(negedge clk);
        wait_done(lat, res, ok);
        check("b2b div latency from c0", 32'(lat + 3), 32'd36);
        check("b2b div result", res, 32'd7);
        check("b2b div stall", {31'h0, ok}, 32'h1);
        start = 1'b0;
        @(negedge clk);
        #1;
        check("b2b done one cycle", {31'h0, done_o}, 32'h0);
        @(negedge clk);

        // Flush at divide iteration 10, then clear held against a fresh start.
        issue(3'd4, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        clear = 1'b1;
        #1;
        check("clear stall busy", {31'h0, stall_o}, 32'h1);
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        #1;
        check("clear no done", {31'h0, done_o}, 32'h0);
        check("clear stall drops", {31'h0, stall_o}, 32'h0);
        clear = 1'b1;
        issue(3'd0, 32'd3, 32'd3);
        repeat (2) @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        seen  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_o === 1'b1) seen = 1;
        end
        check("aborted op never completes", 32'(seen), 32'd0);
        v = '{"post-clear DIVU", 3'd5, 32'd100, 32'd7, 32'd14, 33};
        run_vec(v);

        // Asynchronous reset in the middle of a multiply.
        issue(3'd0, 32'd6, 32'd7);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst result_o", result_o, 32'h0);
        check("async rst done_o", {31'h0, done_o}, 32'h0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Asynchronous reset during the done cycle drops done_o immediately.
        issue(3'd0, 32'd6, 32'd7);
        wait_done(lat, res, ok);
        check("pre-rst mul result", res, 32'd42);
        #1 rst = 1'b1;
        #1;
        check("async rst in done", {31'h0, done_o}, 32'h0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Inputs changing while busy must not disturb the latched operation.
        issue(3'd4, 32'hFFFFFFF9, 32'd2);
        repeat (5) @(negedge clk);
        Op1    = 32'($urandom);
        Op2    = 32'($urandom);
        funct3 = 3'($urandom_range(0, 7));
        wait_done(lat, res, ok);
        start = 1'b0;
        check("opchg latency from c0", 32'(lat + 5), 32'd33);
        check("opchg result", res, 32'hFFFFFFFD);
        check("opchg stall", {31'h0, ok}, 32'h1);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            v.name = $sformatf("rand%0d", i);
            v.f3   = 3'($urandom_range(0, 7));
            v.a    = pick();
            v.b    = pick();
            v.res  = ref_model(v.f3, v.a, v.b);
            v.lat  = ref_lat(v.f3, v.a, v.b);
            run_vec(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
